// File: rtl/sram_cache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_cache_arb_pkg
// Description : Shared types and the round-robin winner helper for the
//               sram_cache port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_cache_arb_pkg;

    typedef enum logic [0:0] {
        INIT  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

    localparam int MAX_PORTS = 4;
    localparam int PTR_W     = $clog2(MAX_PORTS);

    // Requests above the real port count must be zero; the search then wraps
    // modulo MAX_PORTS yet yields the same order as wrapping at the port count.
    function automatic logic [PTR_W-1:0] rr_next(
        input logic [PTR_W-1:0]     ptr,
        input logic [MAX_PORTS-1:0] req
    );
        logic [PTR_W-1:0] idx;
        logic             found;
        rr_next = ptr;
        found   = 1'b0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            idx = ptr + PTR_W'(i);
            if (!found && req[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_cache_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : sram_cache_rr_arb
// Description : Combinational round-robin winner select with a registered
//               priority pointer that advances past each granted requester.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_cache_rr_arb
    import sram_cache_arb_pkg::*;
#(
    parameter int  NUM_PORTS = 2,
    localparam int IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 en_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     idx_o
);

    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     w_win;
    logic [MAX_PORTS-1:0] w_req_pad;
    logic                 w_any;

    always_comb begin
        w_req_pad                = '0;
        w_req_pad[NUM_PORTS-1:0] = req_i;
    end

    assign w_win = rr_next(r_ptr, w_req_pad);
    assign w_any = |req_i;
    assign idx_o = IDX_W'(w_win);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_gnt
            assign gnt_o[gi] = en_i && w_any && (w_win == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (en_i && w_any) begin
            r_ptr <= (w_win == PTR_W'(NUM_PORTS - 1)) ? '0 : w_win + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_cache_port_arbiter
// Description : Round-robin sharing of one sram_cache port among NUM_PORTS
//               requesters, with a zero-fill sweep after reset and on flush.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_cache_port_arbiter
    import sram_cache_arb_pkg::*;
#(
    parameter int  NUM_PORTS  = 2,
    parameter int  DATA_WIDTH = 64,
    parameter int  USER_WIDTH = 1,
    parameter int  NUM_WORDS  = 1024,
    parameter int  AW         = $clog2(NUM_WORDS),
    localparam int BE_W       = (DATA_WIDTH + 7) / 8,
    localparam int IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    output logic                  busy_o,
    input  logic                  req_i    [NUM_PORTS],
    input  logic                  we_i     [NUM_PORTS],
    input  logic [AW-1:0]         addr_i   [NUM_PORTS],
    input  logic [DATA_WIDTH-1:0] wdata_i  [NUM_PORTS],
    input  logic [USER_WIDTH-1:0] wuser_i  [NUM_PORTS],
    input  logic [BE_W-1:0]       be_i     [NUM_PORTS],
    output logic                  gnt_o    [NUM_PORTS],
    output logic                  rvalid_o [NUM_PORTS],
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic [USER_WIDTH-1:0] ruser_o,
    output logic                  sram_req_o,
    output logic                  sram_we_o,
    output logic [AW-1:0]         sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [USER_WIDTH-1:0] sram_wuser_o,
    output logic [BE_W-1:0]       sram_be_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i,
    input  logic [USER_WIDTH-1:0] sram_ruser_i
);

    arb_state_e           r_state;
    arb_state_e           w_state_next;
    logic [AW-1:0]        r_cnt;
    logic [NUM_PORTS-1:0] r_rvalid;
    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_gnt;
    logic [NUM_PORTS-1:0] w_rd_gnt;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_in_init;
    logic                 w_arb_en;
    logic                 w_sweep_last;

    // Reset gates the port combinationally so nothing leaks out while rst_i is high.
    assign w_in_init    = (r_state == INIT) && !rst_i;
    assign w_arb_en     = (r_state == SERVE) && !rst_i && !flush_i;
    assign w_sweep_last = (r_cnt == AW'(NUM_WORDS - 1));
    assign busy_o       = rst_i || (r_state == INIT);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign w_req[gi]    = req_i[gi];
            assign gnt_o[gi]    = w_gnt[gi];
            assign rvalid_o[gi] = r_rvalid[gi] && !rst_i;
        end
    endgenerate

    sram_cache_rr_arb #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (w_req),
        .en_i  (w_arb_en),
        .gnt_o (w_gnt),
        .idx_o (w_idx)
    );

    assign w_rd_gnt = w_gnt & {NUM_PORTS{~we_i[w_idx]}};
    assign rdata_o  = sram_rdata_i;
    assign ruser_o  = sram_ruser_i;

    always_comb begin
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wuser_o = '0;
        sram_be_o    = '0;
        if (w_in_init) begin
            sram_req_o  = 1'b1;
            sram_we_o   = 1'b1;
            sram_addr_o = r_cnt;
            sram_be_o   = '1;
        end else if (|w_gnt) begin
            sram_req_o   = 1'b1;
            sram_we_o    = we_i[w_idx];
            sram_addr_o  = addr_i[w_idx];
            sram_wdata_o = wdata_i[w_idx];
            sram_wuser_o = wuser_i[w_idx];
            sram_be_o    = be_i[w_idx];
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            INIT:    if (w_sweep_last) w_state_next = SERVE;
            SERVE:   if (flush_i)      w_state_next = INIT;
            default: w_state_next = INIT;
        endcase
    end

    // The counter idles at zero in SERVE so every sweep starts from address 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= INIT;
            r_cnt    <= '0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= w_rd_gnt;
            if (r_state == INIT) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire
